// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM peripheral: bus widths,
// register word indices and the byte-enable merge used on register writes.
package led_pwm_pkg;

   localparam int BUS_AW = 5;
   localparam int BUS_DW = 32;
   localparam int BUS_BW = BUS_DW / 8;
   localparam int PRE_W  = 16;
   localparam int IDX_W  = 3;

   localparam logic [IDX_W-1:0] REG_CTRL     = 3'd0;
   localparam logic [IDX_W-1:0] REG_PRESCALE = 3'd1;
   localparam logic [IDX_W-1:0] REG_DUTY0    = 3'd2;

   function automatic logic [BUS_DW-1:0] be_merge(input logic [BUS_DW-1:0] old_word,
                                                  input logic [BUS_DW-1:0] new_word,
                                                  input logic [BUS_BW-1:0] be);
      be_merge = old_word;
      for (int b = 0; b < BUS_BW; b++) begin
         if (be[b]) be_merge[8*b +: 8] = new_word[8*b +: 8];
      end
   endfunction

endpackage

// File: rtl/led_pwm_ctrl_channel.sv
// One PWM output channel: duty shadow reloaded on period wrap, and a
// registered compare against the shared PWM counter.
module pwm_channel #(
   parameter int PWM_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PWM_W-1:0] duty_i,
   input  logic             wrap_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   input  logic             en_i,
   output logic             led_o
);

   logic [PWM_W-1:0] shadow_q, shadow_d;
   logic             led_q, led_d;

   always_comb begin
      shadow_d = wrap_i ? duty_i : shadow_q;
      led_d    = en_i & (pwm_cnt_i < shadow_q);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         led_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         led_q    <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED PWM peripheral: register file with byte enables,
// prescaler, shared PWM counter and NUM_LEDS shadowed PWM channels.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int          NUM_LEDS     = 4,
   parameter int          PWM_W        = 8,
   parameter logic [15:0] PRESCALE_RST = 16'd999
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [BUS_BW-1:0]   be_i,
   input  logic [BUS_AW-1:0]   addr_i,
   input  logic [BUS_DW-1:0]   wdata_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [BUS_DW-1:0]   rdata_o,
   output logic [NUM_LEDS-1:0] led_o
);

   logic [IDX_W-1:0]    reg_idx;
   logic                wr_en, rd_en, tick, wrap;
   logic [NUM_LEDS-1:0] ctrl_q, ctrl_d;
   logic [PRE_W-1:0]    prescale_q, prescale_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [PWM_W-1:0]    duty_q [NUM_LEDS];
   logic [PWM_W-1:0]    duty_d [NUM_LEDS];
   logic                rvalid_q, rvalid_d;
   logic [BUS_DW-1:0]   rdata_q, rdata_d;
   logic [BUS_DW-1:0]   rd_word, wr_word;
   logic                unused_bits;

   assign reg_idx = addr_i[4:2];
   assign wr_en   = req_i & we_i;
   assign rd_en   = req_i & ~we_i;
   assign gnt_o   = req_i;
   assign tick    = (pre_cnt_q == prescale_q);
   assign wrap    = tick & (&pwm_cnt_q);

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      rd_word = '0;
      case (reg_idx)
         REG_CTRL:     rd_word[NUM_LEDS-1:0] = ctrl_q;
         REG_PRESCALE: rd_word[PRE_W-1:0]    = prescale_q;
         default:      ;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (reg_idx == REG_DUTY0 + IDX_W'(i)) rd_word[PWM_W-1:0] = duty_q[i];
      end
   end

   // Writes merge into the current (zero-extended) register value, so
   // disabled bytes keep their contents and unimplemented bits stay 0.
   assign wr_word     = be_merge(rd_word, wdata_i, be_i);
   assign unused_bits = ^{wr_word[BUS_DW-1:PRE_W], addr_i[1:0]};

   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      duty_d     = duty_q;
      pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
      pwm_cnt_d  = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
      if (wr_en) begin
         case (reg_idx)
            REG_CTRL: ctrl_d = wr_word[NUM_LEDS-1:0];
            REG_PRESCALE: begin
               prescale_d = wr_word[PRE_W-1:0];
               pre_cnt_d  = '0;
            end
            default: ;
         endcase
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (reg_idx == REG_DUTY0 + IDX_W'(i)) duty_d[i] = wr_word[PWM_W-1:0];
         end
      end
      rvalid_d = req_i;
      rdata_d  = rd_en ? rd_word : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q     <= '0;
         prescale_q <= PRESCALE_RST;
         pre_cnt_q  <= '0;
         pwm_cnt_q  <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         // NOTE: the duty array is a handful of flops, not a RAM, so it takes a reset like the rest.
         for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         pre_cnt_q  <= pre_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         duty_q     <= duty_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
      pwm_channel #(
         .PWM_W(PWM_W)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .duty_i   (duty_q[g]),
         .wrap_i   (wrap),
         .pwm_cnt_i(pwm_cnt_q),
         .en_i     (ctrl_q[g]),
         .led_o    (led_o[g])
      );
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: bus responses go through a
// scoreboard queue checked by a monitor; LED behaviour is checked inline.
`timescale 1ns/1ps
module tb_led_pwm_ctrl;

   typedef struct packed {
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic        clk, rst_i, req_i, we_i;
   logic [3:0]  be_i;
   logic [4:0]  addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o, rvalid_o;
   logic [31:0] rdata_o;
   logic [3:0]  led_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   led_pwm_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .we_i    (we_i),
      .be_i    (be_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .gnt_o   (gnt_o),
      .rvalid_o(rvalid_o),
      .rdata_o (rdata_o),
      .led_o   (led_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required normal completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: rvalid must follow each granted request by exactly one cycle.
   initial begin : monitor
      logic prev_req, prev_rv;
      exp_t e;
      prev_rv = 1'b0;
      forever begin
         @(posedge clk);
         prev_req = req_i && !rst_i;
         @(negedge clk);
         if (prev_req || rvalid_o) begin
            check("rvalid", rvalid_o, prev_req);
            if (rvalid_o && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (e.chk) check("rdata", rdata_o, e.data);
            end
         end else if (prev_rv) begin
            check("rdata_idle", rdata_o, 32'h0);
         end
         prev_rv = rvalid_o;
      end
   end

   // Starts and ends at posedge+1; one request occupies exactly one cycle.
   task automatic bus_op(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_rd);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = {idx, 2'b00};
      wdata_i = wd;
      be_i    = be;
      exp_q.push_back('{chk: !we, data: exp_rd});
      @(negedge clk);
      check("gnt", {31'd0, gnt_o}, 32'd1);
      @(posedge clk); #1;
      req_i = 1'b0;
      we_i  = 1'b0;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
      bus_op(1'b1, idx, wd, 4'hF, 32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_rise(input int bound);
      logic prev, found;
      prev  = led_o[0];
      found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge clk);
         if (!prev && led_o[0]) found = 1'b1;
         prev = led_o[0];
      end
      check("led0_rise_seen", {31'd0, found}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Called right after wait_rise: the rise cycle is relative cycle 0 and is high.
   task automatic count_led0(input int total, input int win, input int wr_cyc,
                             input logic [2:0] widx, input logic [31:0] wdat,
                             output int h0, output int h1, output int h2);
      int h[3];
      h = '{1, 0, 0};
      for (int i = 1; i < total; i++) begin
         if (i == wr_cyc) begin
            req_i = 1'b1; we_i = 1'b1; addr_i = {widx, 2'b00}; wdata_i = wdat; be_i = 4'hF;
            exp_q.push_back('{chk: 1'b0, data: 32'h0});
         end else begin
            req_i = 1'b0; we_i = 1'b0;
         end
         @(negedge clk);
         if (led_o[0]) h[i / win]++;
         @(posedge clk); #1;
      end
      req_i = 1'b0; we_i = 1'b0;
      h0 = h[0]; h1 = h[1]; h2 = h[2];
   endtask

   initial begin : stim
      int cnt[4];
      int h0, h1, h2;
      logic [31:0] rst_vals[8];
      rst_vals = '{32'd0, 32'd999, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;

      // Reset state
      repeat (3) begin
         @(negedge clk);
         check("led_in_reset", {28'd0, led_o}, 32'd0);
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) bus_op(1'b0, 3'(i), 32'h0, 4'h0, rst_vals[i]);
      @(negedge clk);
      check("led_after_reset", {28'd0, led_o}, 32'd0);
      idle(1);

      // Handshake, back-to-back, byte enables
      wr(3'd1, 32'h0000_0003);
      bus_op(1'b0, 3'd1, 32'h0, 4'h0, 32'h3);
      bus_op(1'b0, 3'd1, 32'h0, 4'h0, 32'h3);
      bus_op(1'b1, 3'd1, 32'h0000_ABCD, 4'b0010, 32'h0);
      bus_op(1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_AB03);
      bus_op(1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0);
      bus_op(1'b0, 3'd0, 32'h0, 4'h0, 32'h0000_000F);
      wr(3'd7, 32'hFFFF_FFFF);
      bus_op(1'b0, 3'd7, 32'h0, 4'h0, 32'h0);
      idle(2);

      // PWM duty over two full periods
      wr(3'd1, 32'd0);
      wr(3'd0, 32'hF);
      wr(3'd2, 32'd64);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd255);
      wr(3'd5, 32'd128);
      bus_op(1'b0, 3'd4, 32'h0, 4'h0, 32'd255);
      idle(300);
      cnt = '{0, 0, 0, 0};
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) if (led_o[j]) cnt[j]++;
         @(posedge clk); #1;
      end
      check("duty_led0", cnt[0], 32'd128);
      check("duty_led1", cnt[1], 32'd0);
      check("duty_led2", cnt[2], 32'd510);
      check("duty_led3", cnt[3], 32'd256);

      // Shadowing: mid-period write, then a write on the wrap cycle
      wait_rise(1100);
      count_led0(768, 256, 100, 3'd2, 32'd200, h0, h1, h2);
      check("shadow_mid_p0", h0, 32'd64);
      check("shadow_mid_p1", h1, 32'd200);
      check("shadow_mid_p2", h2, 32'd200);
      wait_rise(1100);
      count_led0(768, 256, 254, 3'd2, 32'd32, h0, h1, h2);
      check("shadow_wrap_p0", h0, 32'd200);
      check("shadow_wrap_p1", h1, 32'd200);
      check("shadow_wrap_p2", h2, 32'd32);
      bus_op(1'b0, 3'd2, 32'h0, 4'h0, 32'd32);

      // Enable takes effect at N+2 without a wrap
      wr(3'd2, 32'd255);
      idle(600);
      wait_rise(1100);
      idle(3);
      wr(3'd0, 32'h0);
      @(negedge clk);
      check("en_n1_led0", {31'd0, led_o[0]}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("en_n2_off", {28'd0, led_o}, 32'd0);
      @(posedge clk); #1;

      // Prescale = 3 and restart of spacing by rewriting PRESCALE
      wr(3'd2, 32'd1);
      wr(3'd0, 32'h1);
      wr(3'd1, 32'd3);
      idle(1100);
      wait_rise(2100);
      count_led0(3072, 1024, 1, 3'd1, 32'd3, h0, h1, h2);
      check("pre_restart_run", h0, 32'd7);
      check("pre_period1", h1, 32'd4);
      check("pre_period2", h2, 32'd4);

      // Reset mid-run, with a read issued in the reset cycle
      wr(3'd0, 32'hF);
      idle(40);
      @(negedge clk);
      check("led_before_rst", {28'd0, led_o}, 32'hC);
      @(posedge clk); #1;
      rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 5'd0;
      @(posedge clk); #1;
      rst_i = 1'b0; req_i = 1'b0;
      @(negedge clk);
      check("led_after_midrst", {28'd0, led_o}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) bus_op(1'b0, 3'(i), 32'h0, 4'h0, rst_vals[i]);
      idle(20);
      @(negedge clk);
      check("led_idle_after_rst", {28'd0, led_o}, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Memory-mapped LED peripheral on the Ibex data bus that drives the board's 4-bit LED output. It is the stage directly upstream of the LED pins: it takes CPU register writes and produces glitch-free per-LED PWM brightness on `led_o`. It sits behind the data-bus address decoder, alongside RAM, and only ever sees accesses already decoded to its window.

## Interface
Parameters:
- `NUM_LEDS`, 4: number of LED channels.
- `PWM_W`, 8: PWM counter and duty width.
- `PRESCALE_RST`, 16'd999: reset value of the PRESCALE register.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  bus request, already decoded to this block.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `addr_i`  in  5  byte address within the window; bits [4:2] select the register.
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  grant.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  32  read data.
- `led_o`  out  NUM_LEDS  LED drive, registered.

## Operation
- Registers, by word index on `addr_i[4:2]`:
  - 0 CTRL: bits [NUM_LEDS-1:0] are per-LED enables.
  - 1 PRESCALE: bits [15:0].
  - 2..2+NUM_LEDS-1 DUTY[i]: bits [PWM_W-1:0].
- Other indices are unmapped: reads return 0, writes are ignored, and no error is raised.
- Write data honours `be_i` byte-wise. Unimplemented bits read as 0.
- Prescaler:
  - 16-bit `pre_cnt` counts 0..PRESCALE.
  - A `tick` is generated when `pre_cnt == PRESCALE`, and `pre_cnt` then returns to 0.
  - Tick period is PRESCALE+1 cycles. PRESCALE=0 gives a tick every cycle.
- A write to PRESCALE clears `pre_cnt` in the same cycle the write is applied.
- PWM counter:
  - `pwm_cnt` (PWM_W bits) increments on each tick and wraps from 2^PWM_W−1 to 0.
  - `wrap` = tick while `pwm_cnt` is at all-ones.
- Duty shadowing:
  - The bus writes the active DUTY register.
  - On `wrap`, each active DUTY is copied into its shadow. Only shadows drive the output, so there are no mid-period glitches.
  - Reads return the active (not shadow) value.
- Output: `led_o[i]` next = CTRL[i] & (`pwm_cnt` < shadow[i]).
  - duty 0 means always off.
  - duty 2^PWM_W−1 means on for 255 of 256 counts.
- A CTRL enable change takes effect without waiting for a wrap.

## Timing
- `gnt_o` is combinational and equals `req_i`. Every request is accepted in its cycle.
- `rvalid_o` asserts exactly 1 cycle after the granted request, for both reads and writes.
- `rdata_o` is valid when `rvalid_o` is high and is 0 otherwise.
- Register writes are visible to a read issued in the next cycle.
- A CTRL write in cycle N affects `led_o` in cycle N+2: register update, then output flop.
- Back-to-back requests every cycle are supported, with one rvalid per request in order.
- Reset values:
  - All registers 0 except PRESCALE = PRESCALE_RST.
  - Shadows 0, `pre_cnt` 0, `pwm_cnt` 0.
  - `led_o` 0, `rvalid_o` 0, `rdata_o` 0.
- Reset mid-operation: all state returns to reset values on the next edge and any pending rvalid is dropped.
- Simultaneous events:
  - A DUTY write in the same cycle as `wrap`: the shadow takes the old active value, and the new value is shadowed at the next wrap.
  - A PRESCALE write on a tick cycle: the tick still advances `pwm_cnt` once, and `pre_cnt` is cleared.

## Structure
- Shared package `led_pwm_pkg` holds:
  - register index constants `REG_CTRL`, `REG_PRESCALE`, `REG_DUTY0`;
  - `localparam` widths.
- One sub-module, `pwm_channel`:
  - holds one shadow register and the compare logic;
  - inputs are duty, wrap, pwm_cnt and enable; output is the LED bit;
  - instantiated NUM_LEDS times in a generate loop.
- Bus decode, registers, prescaler and PWM counter stay in the top `led_pwm_ctrl`.

## Test plan
- **Reset**: hold `rst_i` high for 3 cycles, then read every register.
  - CTRL, DUTY0..3 and index 7 read 0; PRESCALE reads 999.
  - `led_o`=0 throughout.
- **Bus handshake**: write PRESCALE=0x0003, then read it back on consecutive cycles.
  - `gnt_o` is high in the request cycles.
  - `rvalid_o` is high exactly one cycle after each request.
  - rdata=0x3.
  - A write with `be_i`=4'b0010 and wdata=0xABCD changes only bits [15:8], so the readback is 0xAB03.
- **PWM duty**: PRESCALE=0, CTRL=0xF, DUTY0=64, DUTY1=0, DUTY2=255, DUTY3=128, then run 512 cycles after the first wrap.
  - High counts per 256-cycle period: LED0=64, LED1=0, LED2=255, LED3=128.
- **Shadowing**: with DUTY0=64 running, write DUTY0=200 mid-period.
  - The current period still shows 64 high cycles; the next period shows 200.
  - A write landing exactly on the wrap cycle is delayed one full period.
- **Enable**: with DUTY0=255 running, write CTRL=0.
  - `led_o[0]` is 0 two cycles after the write, without waiting for a wrap.
- **Prescale / reset mid-run**: PRESCALE=3 gives `pwm_cnt` increments every 4 cycles.
  - Rewriting PRESCALE=3 mid-count restarts the 4-cycle spacing from the write.
  - Asserting `rst_i` for 1 cycle mid-period returns `led_o` to 0 and all registers to their reset values.
